// File: rtl/cpu_types_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_types_pkg
// Brief    : Shared CPU types and branch-target-buffer default sizing.
// Revision : 1.0 - initial BTB constants
// ============================================================================
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  localparam int BTB_ENTRIES_DEFAULT  = 16;
  localparam int BTB_CTR_BITS_DEFAULT = 2;

endpackage
`default_nettype wire

// File: rtl/branch_predictor_if.sv
`default_nettype none
// ============================================================================
// Module   : branch_predictor_if
// Brief    : Fetch lookup, MEM-stage update and statistics bundle of the BTB.
// Revision : 1.0 - initial
// ============================================================================
interface branch_predictor_if;
  import cpu_types_pkg::*;

  word_t pc;
  logic  hit;
  logic  pred_taken;
  word_t pred_target;
  logic  upd_en;
  word_t upd_pc;
  logic  upd_taken;
  word_t upd_target;
  logic  flush_tbl;
  logic  mispredict;
  word_t upd_cnt;
  word_t miss_cnt;

  modport master (
    output pc, upd_en, upd_pc, upd_taken, upd_target, flush_tbl,
    input  hit, pred_taken, pred_target, mispredict, upd_cnt, miss_cnt
  );

  modport slave (
    input  pc, upd_en, upd_pc, upd_taken, upd_target, flush_tbl,
    output hit, pred_taken, pred_target, mispredict, upd_cnt, miss_cnt
  );

endinterface
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : sat_counter
// Brief    : Up/down counter clamped at 0 and all-ones, with parallel load.
// Revision : 1.0 - initial
// ============================================================================
module sat_counter #(
  parameter int WIDTH = 2
) (
  input  wire logic             CLK,
  input  wire logic             RST,
  input  wire logic             inc,
  input  wire logic             dec,
  input  wire logic             load,
  input  wire logic [WIDTH-1:0] load_val,
  output logic      [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] c_max = '1;
  localparam logic [WIDTH-1:0] c_one = WIDTH'(1);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_val;
    end else if (inc) begin
      if (r_count != c_max) r_count <= r_count + c_one;
    end else if (dec) begin
      if (r_count != '0) r_count <= r_count - c_one;
    end
  end

  assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
// Module   : branch_predictor
// Brief    : Direct-mapped BTB with per-entry saturating direction counters.
// Revision : 1.0 - initial
// ============================================================================
module branch_predictor
  import cpu_types_pkg::*;
#(
  parameter int ENTRIES  = BTB_ENTRIES_DEFAULT,
  parameter int CTR_BITS = BTB_CTR_BITS_DEFAULT
) (
  input wire logic           CLK,
  input wire logic           RST,
  branch_predictor_if.slave  bus
);

  localparam int IDXW = $clog2(ENTRIES);
  localparam int TAGW = 30 - IDXW;
  localparam logic [CTR_BITS-1:0] c_weak_taken = CTR_BITS'(1) << (CTR_BITS - 1);

  typedef struct packed {
    logic            valid;
    logic [TAGW-1:0] tag;
    logic [29:0]     target;
  } entry_t;

  entry_t            r_tbl [ENTRIES];
  logic [CTR_BITS-1:0] w_ctr [ENTRIES];
  word_t             r_upd_cnt;
  word_t             r_miss_cnt;

  // Fetch-side read port
  logic [IDXW-1:0] w_l_idx;
  logic [TAGW-1:0] w_l_tag;
  entry_t          w_l_ent;
  logic            w_l_hit;
  logic            w_l_taken;

  assign w_l_idx   = bus.pc[IDXW+1:2];
  assign w_l_tag   = bus.pc[31:IDXW+2];
  assign w_l_ent   = r_tbl[w_l_idx];
  assign w_l_hit   = w_l_ent.valid && (w_l_ent.tag == w_l_tag);
  assign w_l_taken = w_l_hit && w_ctr[w_l_idx][CTR_BITS-1];

  assign bus.hit         = w_l_hit;
  assign bus.pred_taken  = w_l_taken;
  assign bus.pred_target = w_l_taken ? {w_l_ent.target, 2'b00} : bus.pc + 32'd4;

  // Update-side read port: re-derives what fetch would have predicted
  logic [IDXW-1:0] w_u_idx;
  logic [TAGW-1:0] w_u_tag;
  entry_t          w_u_ent;
  logic            w_u_hit;
  logic            w_u_taken;
  word_t           w_u_target;
  logic            w_mispredict;

  assign w_u_idx    = bus.upd_pc[IDXW+1:2];
  assign w_u_tag    = bus.upd_pc[31:IDXW+2];
  assign w_u_ent    = r_tbl[w_u_idx];
  assign w_u_hit    = w_u_ent.valid && (w_u_ent.tag == w_u_tag);
  assign w_u_taken  = w_u_hit && w_ctr[w_u_idx][CTR_BITS-1];
  assign w_u_target = w_u_taken ? {w_u_ent.target, 2'b00} : bus.upd_pc + 32'd4;

  assign w_mispredict = bus.upd_en &&
                        ((w_u_taken != bus.upd_taken) ||
                         (bus.upd_taken && (w_u_target != bus.upd_target)));
  assign bus.mispredict = w_mispredict;

  // A flush in the same cycle suppresses every table write
  logic w_wr;
  logic w_hit_wr;
  logic w_alloc;

  assign w_wr     = bus.upd_en && !bus.flush_tbl;
  assign w_hit_wr = w_wr && w_u_hit;
  assign w_alloc  = w_wr && !w_u_hit && bus.upd_taken;

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < ENTRIES; i++) r_tbl[i] <= '0;
    end else if (bus.flush_tbl) begin
      for (int i = 0; i < ENTRIES; i++) r_tbl[i].valid <= 1'b0;
    end else if (w_alloc) begin
      r_tbl[w_u_idx] <= '{valid: 1'b1, tag: w_u_tag, target: bus.upd_target[31:2]};
    end else if (w_hit_wr && bus.upd_taken) begin
      r_tbl[w_u_idx].target <= bus.upd_target[31:2];
    end
  end

  generate
    for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_ctr
      logic w_sel;
      assign w_sel = (w_u_idx == IDXW'(gi));

      sat_counter #(
        .WIDTH (CTR_BITS)
      ) u_ctr (
        .CLK      (CLK),
        .RST      (RST),
        .inc      (w_hit_wr && bus.upd_taken && w_sel),
        .dec      (w_hit_wr && !bus.upd_taken && w_sel),
        .load     (w_alloc && w_sel),
        .load_val (c_weak_taken),
        .count    (w_ctr[gi])
      );
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_upd_cnt  <= '0;
      r_miss_cnt <= '0;
    end else begin
      if (bus.upd_en && (r_upd_cnt != '1))  r_upd_cnt  <= r_upd_cnt + 32'd1;
      if (w_mispredict && (r_miss_cnt != '1)) r_miss_cnt <= r_miss_cnt + 32'd1;
    end
  end

  assign bus.upd_cnt  = r_upd_cnt;
  assign bus.miss_cnt = r_miss_cnt;

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_predictor
// Brief    : Directed vector table plus reset-collision sequence for the BTB.
// Revision : 1.0 - initial
// ============================================================================
module tb_branch_predictor;

  logic CLK = 1'b0;
  logic RST;

  always #5 CLK = ~CLK;

  branch_predictor_if bus ();

  branch_predictor #(
    .ENTRIES  (16),
    .CTR_BITS (2)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  typedef struct {
    logic        flush;
    logic        upd_en;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic [31:0] pc;
    logic        hit;
    logic        pt;
    logic [31:0] ptgt;
    logic        misp;
    logic [31:0] ucnt;
    logic [31:0] mcnt;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic vec_t mk(logic fl, logic ue, logic [31:0] upc, logic ut,
                              logic [31:0] utg, logic [31:0] p, logic h,
                              logic t, logic [31:0] tg, logic m,
                              logic [31:0] uc, logic [31:0] mc);
    vec_t v;
    v.flush = fl; v.upd_en = ue; v.upd_pc = upc; v.upd_taken = ut;
    v.upd_target = utg; v.pc = p; v.hit = h; v.pt = t; v.ptgt = tg;
    v.misp = m; v.ucnt = uc; v.mcnt = mc;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic fl, input logic ue, input logic [31:0] upc,
                       input logic ut, input logic [31:0] utg, input logic [31:0] p);
    bus.flush_tbl  = fl;
    bus.upd_en     = ue;
    bus.upd_pc     = upc;
    bus.upd_taken  = ut;
    bus.upd_target = utg;
    bus.pc         = p;
  endtask

  initial begin
    // Each row: inputs for one cycle; expectations are the pre-edge outputs.
    //            fl ue  upd_pc  ut upd_tgt  pc      hit pt ptgt     mp ucnt mcnt
    vecs.push_back(mk(0, 0, 32'h0,   0, 32'h0,   32'h100, 0, 0, 32'h104, 0, 0,  0));
    vecs.push_back(mk(0, 1, 32'h40,  1, 32'h80,  32'h40,  0, 0, 32'h44,  1, 0,  0));
    vecs.push_back(mk(0, 0, 32'h0,   0, 32'h0,   32'h40,  1, 1, 32'h80,  0, 1,  1));
    vecs.push_back(mk(0, 1, 32'h40,  1, 32'h80,  32'h40,  1, 1, 32'h80,  0, 1,  1));
    vecs.push_back(mk(0, 1, 32'h40,  1, 32'h80,  32'h40,  1, 1, 32'h80,  0, 2,  1));
    vecs.push_back(mk(0, 1, 32'h40,  0, 32'h300, 32'h40,  1, 1, 32'h80,  1, 3,  1));
    vecs.push_back(mk(0, 1, 32'h40,  0, 32'h300, 32'h40,  1, 1, 32'h80,  1, 4,  2));
    vecs.push_back(mk(0, 0, 32'h0,   0, 32'h0,   32'h40,  1, 0, 32'h44,  0, 5,  3));
    vecs.push_back(mk(0, 1, 32'h40,  0, 32'h300, 32'h40,  1, 0, 32'h44,  0, 5,  3));
    vecs.push_back(mk(0, 1, 32'h40,  0, 32'h300, 32'h40,  1, 0, 32'h44,  0, 6,  3));
    vecs.push_back(mk(0, 1, 32'h40,  1, 32'h80,  32'h40,  1, 0, 32'h44,  1, 7,  3));
    vecs.push_back(mk(0, 1, 32'h40,  1, 32'h80,  32'h40,  1, 0, 32'h44,  1, 8,  4));
    vecs.push_back(mk(0, 0, 32'h0,   0, 32'h0,   32'h40,  1, 1, 32'h80,  0, 9,  5));
    vecs.push_back(mk(0, 1, 32'h40,  1, 32'hC0,  32'h40,  1, 1, 32'h80,  1, 9,  5));
    vecs.push_back(mk(0, 0, 32'h0,   0, 32'h0,   32'h40,  1, 1, 32'hC0,  0, 10, 6));
    vecs.push_back(mk(0, 1, 32'h80,  1, 32'h200, 32'h80,  0, 0, 32'h84,  1, 10, 6));
    vecs.push_back(mk(0, 0, 32'h0,   0, 32'h0,   32'h40,  0, 0, 32'h44,  0, 11, 7));
    vecs.push_back(mk(0, 0, 32'h0,   0, 32'h0,   32'h80,  1, 1, 32'h200, 0, 11, 7));
    vecs.push_back(mk(0, 1, 32'h10,  0, 32'h0,   32'h10,  0, 0, 32'h14,  0, 11, 7));
    vecs.push_back(mk(0, 0, 32'h0,   0, 32'h0,   32'h10,  0, 0, 32'h14,  0, 12, 7));
    vecs.push_back(mk(1, 1, 32'h20,  1, 32'h400, 32'h80,  1, 1, 32'h200, 1, 12, 7));
    vecs.push_back(mk(0, 0, 32'h0,   0, 32'h0,   32'h20,  0, 0, 32'h24,  0, 13, 8));
    vecs.push_back(mk(0, 0, 32'h0,   0, 32'h0,   32'h80,  0, 0, 32'h84,  0, 13, 8));
    vecs.push_back(mk(0, 0, 32'h0,   0, 32'h0,   32'h40,  0, 0, 32'h44,  0, 13, 8));

    RST = 1'b1;
    drive(0, 0, 32'h0, 0, 32'h0, 32'h100);
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].flush, vecs[i].upd_en, vecs[i].upd_pc, vecs[i].upd_taken,
            vecs[i].upd_target, vecs[i].pc);
      @(negedge CLK);
      chk($sformatf("v%0d.hit", i),         {31'd0, bus.hit},        {31'd0, vecs[i].hit});
      chk($sformatf("v%0d.pred_taken", i),  {31'd0, bus.pred_taken}, {31'd0, vecs[i].pt});
      chk($sformatf("v%0d.pred_target", i), bus.pred_target,         vecs[i].ptgt);
      chk($sformatf("v%0d.mispredict", i),  {31'd0, bus.mispredict}, {31'd0, vecs[i].misp});
      chk($sformatf("v%0d.upd_cnt", i),     bus.upd_cnt,             vecs[i].ucnt);
      chk($sformatf("v%0d.miss_cnt", i),    bus.miss_cnt,            vecs[i].mcnt);
      @(posedge CLK);
      #1;
    end

    // Allocate an entry in a fresh index, then reset on top of flush + update.
    drive(0, 1, 32'h44, 1, 32'h100, 32'h44);
    @(posedge CLK);
    #1 drive(0, 0, 32'h0, 0, 32'h0, 32'h44);
    @(negedge CLK);
    chk("alloc44.hit",         {31'd0, bus.hit},        32'd1);
    chk("alloc44.pred_target", bus.pred_target,         32'h100);
    chk("alloc44.upd_cnt",     bus.upd_cnt,             32'd14);
    chk("alloc44.miss_cnt",    bus.miss_cnt,            32'd9);
    @(posedge CLK);
    #1;
    RST = 1'b1;
    drive(1, 1, 32'h24, 1, 32'h500, 32'h44);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    drive(0, 0, 32'h0, 0, 32'h0, 32'h44);
    @(negedge CLK);
    chk("rst_ovr.hit44",       {31'd0, bus.hit},        32'd0);
    chk("rst_ovr.pred_target", bus.pred_target,         32'h48);
    chk("rst_ovr.upd_cnt",     bus.upd_cnt,             32'd0);
    chk("rst_ovr.miss_cnt",    bus.miss_cnt,            32'd0);
    bus.pc = 32'h24;
    #1;
    chk("rst_ovr.hit24",       {31'd0, bus.hit},        32'd0);
    chk("rst_ovr.pt24",        {31'd0, bus.pred_taken}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 The block SHALL take parameter ENTRIES, default 16, giving the number of BTB entries; it is a power of two, at least 2.
REQ-002 The block SHALL take parameter CTR_BITS, default 2, giving the saturating counter width; it is at least 1.
REQ-003 The block SHALL have port CLK, input, 1 bit: the single clock, with all state updating on its rising edge.
REQ-004 The block SHALL have port RST, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port pc, input, 32 bits: the fetch-stage lookup address.
REQ-006 The block SHALL have port hit, output, 1 bit: a valid entry whose tag matches pc exists.
REQ-007 The block SHALL have port pred_taken, output, 1 bit: hit is 1 and the counter MSB is 1.
REQ-008 The block SHALL have port pred_target, output, 32 bits: {stored target, 2'b00} when pred_taken is 1, else pc+4.
REQ-009 The block SHALL have port upd_en, input, 1 bit: the resolved-branch update strobe from the MEM stage.
REQ-010 The block SHALL have port upd_pc, input, 32 bits: the PC of the resolved branch or jump.
REQ-011 The block SHALL have port upd_taken, input, 1 bit: the actual direction.
REQ-012 The block SHALL have port upd_target, input, 32 bits: the actual target.
REQ-013 The block SHALL have port flush_tbl, input, 1 bit: invalidate all entries.
REQ-014 The block SHALL have port mispredict, output, 1 bit: combinational; the current update was mispredicted.
REQ-015 The block SHALL have port upd_cnt, output, 32 bits: the number of accepted updates.
REQ-016 The block SHALL have port miss_cnt, output, 32 bits: the number of mispredicted updates.

Function
REQ-017 Index SHALL be pc[IDXW+1:2] with IDXW=log2(ENTRIES); tag SHALL be pc[31:IDXW+2]; each entry SHALL hold valid, tag, target[31:2] and ctr.
REQ-018 Lookup SHALL be purely combinational from registered table state, with zero-cycle latency.
REQ-019 On upd_en, the prediction SHALL be formed for upd_pc through a second read port from pre-edge state, using the same rules as REQ-006 to REQ-008.
REQ-020 mispredict SHALL be upd_en AND (predicted direction != upd_taken, OR (upd_taken AND predicted target != upd_target)).
REQ-021 On an update hit, ctr SHALL saturate-increment if taken and saturate-decrement if not taken, with bounds 0 and 2^CTR_BITS-1; the target SHALL be overwritten only when upd_taken is 1.
REQ-022 On an update miss with upd_taken=1, the block SHALL allocate the indexed entry (overwriting any alias): valid=1, new tag, target, ctr=2^(CTR_BITS-1) (weakly taken).
REQ-023 On an update miss with upd_taken=0, the table SHALL be unchanged.
REQ-024 Table writes SHALL take effect at the clock edge; a same-cycle lookup of the updated index SHALL return pre-edge contents.
REQ-025 flush_tbl SHALL clear all valid bits in one cycle; if flush_tbl and upd_en are both asserted, flush SHALL win, no entry is written, and the counters still count the update.
REQ-026 upd_cnt SHALL increment on each upd_en cycle; miss_cnt SHALL increment when mispredict is 1; both SHALL saturate at 32'hFFFFFFFF.
REQ-027 Lookup and update SHALL proceed independently; pc SHALL never affect table state.

Reset
REQ-028 While RST is 1 at an edge, all valid bits, ctr values, tags, targets, upd_cnt and miss_cnt SHALL become 0.
REQ-029 After reset, hit=0, pred_taken=0 and pred_target=pc+4.
REQ-030 RST SHALL override flush_tbl and upd_en in the same cycle.

Structure
REQ-031 word_t SHALL come from cpu_types_pkg, and that package SHALL gain the constants BTB_ENTRIES_DEFAULT=16 and BTB_CTR_BITS_DEFAULT=2.
REQ-032 The entry struct SHALL stay local to the module, because it depends on the parameters.
REQ-033 The per-entry counter SHALL be a sub-module sat_counter (parameter WIDTH; inputs inc, dec, load, load_val; output count), instantiated ENTRIES times.

Verification
REQ-034 Reset scenario: assert RST, then pc=0x100 SHALL give hit=0, pred_taken=0, pred_target=0x104, upd_cnt=0, miss_cnt=0.
REQ-035 Allocate scenario: upd pc=0x40, taken=1, target=0x80 SHALL give mispredict=1; the next cycle, pc=0x40 SHALL give hit=1, pred_taken=1, pred_target=0x80, miss_cnt=1.
REQ-036 Saturation scenario: after REQ-035, two more taken updates to 0x40 SHALL reach ctr=3; two not-taken updates SHALL reach ctr=1; pc=0x40 SHALL then give pred_taken=0, pred_target=0x44.
REQ-037 Alias scenario: after 0x40 is allocated, a taken update at 0x80 (same index 0) with target 0x200 SHALL make pc=0x40 give hit=0 and pc=0x80 give pred_target=0x200.
REQ-038 Not-taken miss scenario: upd pc=0x10, taken=0 on an empty table SHALL give mispredict=0, upd_cnt+1, miss_cnt unchanged, and the table unchanged.
REQ-039 Flush collision scenario: flush_tbl=1 together with a taken update at 0x20 SHALL leave pc=0x20 and all prior entries giving hit=0 the next cycle, with upd_cnt incremented.
